mem_stage: RTL and testbench

Memory-access stage of the five-stage pipelined CPU, sitting directly downstream of the EX/MEM pipeline register and feeding the write-back stage. It performs word loads and stores against an internal data memory and resolves branch and jump redirects. It raises a stall while a multi-cycle memory access is in progress and registers the MEM/WB pipeline outputs. Stall and flush go to the hazard/PC logic. All registered results go to write-back.

---
 rtl/mem_stage.sv | 155 +++++++++++++++
 tb/tb_mem_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Memory-access stage of a five-stage pipelined CPU. Does word
//            loads/stores against an internal data memory, resolves branch
//            and jump redirects, stalls the upstream pipeline during
//            multi-cycle memory accesses and registers the MEM/WB outputs.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            WB, M, ZeroMEM       - control from EX/MEM
//            ALUOut, WD, rd_rt    - address/result, store data, dest reg
//            branch_PC, jump_addr - redirect targets
//            stall, flush,        - combinational hazard/PC controls
//            target_pc
//            WB_Reg, RD_Reg, ALU_Reg, rd_rt_Reg, misalign_Reg
//                                 - registered MEM/WB outputs
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int DEPTH_LOG2 = 8,
    parameter int MEM_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  WB,
    input  logic [3:0]  M,
    input  logic        ZeroMEM,
    input  logic [31:0] ALUOut,
    input  logic [31:0] WD,
    input  logic [4:0]  rd_rt,
    input  logic [31:0] branch_PC,
    input  logic [31:0] jump_addr,
    output logic        stall,
    output logic        flush,
    output logic [31:0] target_pc,
    output logic [2:0]  WB_Reg,
    output logic [31:0] RD_Reg,
    output logic [31:0] ALU_Reg,
    output logic [4:0]  rd_rt_Reg,
    output logic        misalign_Reg
);

    localparam int         c_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] c_LAT_LAST = 4'(MEM_LAT - 1);
    localparam bit         c_MULTI    = (MEM_LAT > 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_nxt;

    logic [31:0]             r_mem [c_DEPTH];

    logic                    w_memop;
    logic                    w_misaligned;
    logic                    w_aligned_op;
    logic                    w_load;
    logic                    w_we;
    logic                    w_jump;
    logic                    w_taken;
    logic [DEPTH_LOG2-1:0]   w_idx;
    logic [31:0]             w_rdata;
    logic                    w_unused_addr;

    assign w_memop      = M[1] | M[0];
    assign w_misaligned = w_memop & (ALUOut[1:0] != 2'b00);
    assign w_aligned_op = w_memop & ~w_misaligned;
    // A combined read+write request behaves as a store and returns no data.
    assign w_load       = M[1] & ~M[0] & ~w_misaligned;
    // Stores commit only on the non-stalled (completion) edge, so a store
    // interrupted by reset never reaches the array.
    assign w_we         = M[0] & ~w_misaligned & ~stall;

    // Upper address bits are intentionally dropped: addresses wrap.
    assign w_idx         = ALUOut[DEPTH_LOG2+1:2];
    assign w_unused_addr = ^ALUOut[31:DEPTH_LOG2+2];

    // Asynchronous read sees contents before any same-cycle write.
    assign w_rdata = r_mem[w_idx];

    assign w_jump    = M[3];
    assign w_taken   = M[2] & ZeroMEM;
    assign target_pc = w_jump ? jump_addr : branch_PC;
    assign flush     = (w_jump | w_taken) & ~stall;

    // Next-state logic; stall is the Moore/Mealy "not yet complete" output.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        stall       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_aligned_op && c_MULTI) begin
                    stall       = 1'b1;
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = 4'd1;
                end
            end
            S_BUSY: begin
                // In BUSY cnt ranges 1..c_LAT_LAST; equality marks completion.
                if (r_cnt != c_LAT_LAST) begin
                    stall     = 1'b1;
                    w_cnt_nxt = r_cnt + 4'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Data memory contents are not reset.
    always_ff @(posedge clk) begin
        if (!rst && w_we) begin
            r_mem[w_idx] <= WD;
        end
    end

    // MEM/WB register: bubble on stalled edges.
    always_ff @(posedge clk) begin
        if (rst || stall) begin
            WB_Reg       <= 3'd0;
            RD_Reg       <= 32'd0;
            ALU_Reg      <= 32'd0;
            rd_rt_Reg    <= 5'd0;
            misalign_Reg <= 1'b0;
        end else begin
            WB_Reg       <= w_misaligned ? 3'd0 : WB;
            RD_Reg       <= w_load ? w_rdata : 32'd0;
            ALU_Reg      <= ALUOut;
            rd_rt_Reg    <= rd_rt;
            misalign_Reg <= w_misaligned;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage. Three instances share one
//            input set: MEM_LAT=1 (index 0), 3 (index 1) and 4 (index 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [2:0]  WB;
    logic [3:0]  M;
    logic        ZeroMEM;
    logic [31:0] ALUOut;
    logic [31:0] WD;
    logic [4:0]  rd_rt;
    logic [31:0] branch_PC;
    logic [31:0] jump_addr;

    logic [2:0]        st;
    logic [2:0]        fl;
    logic [2:0][31:0]  tg;
    logic [2:0][2:0]   wbr;
    logic [2:0][31:0]  rdr;
    logic [2:0][31:0]  alur;
    logic [2:0][4:0]   rdtr;
    logic [2:0]        misr;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.DEPTH_LOG2(8), .MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .WB(WB), .M(M), .ZeroMEM(ZeroMEM),
        .ALUOut(ALUOut), .WD(WD), .rd_rt(rd_rt), .branch_PC(branch_PC),
        .jump_addr(jump_addr), .stall(st[0]), .flush(fl[0]),
        .target_pc(tg[0]), .WB_Reg(wbr[0]), .RD_Reg(rdr[0]),
        .ALU_Reg(alur[0]), .rd_rt_Reg(rdtr[0]), .misalign_Reg(misr[0])
    );

    mem_stage #(.DEPTH_LOG2(8), .MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .WB(WB), .M(M), .ZeroMEM(ZeroMEM),
        .ALUOut(ALUOut), .WD(WD), .rd_rt(rd_rt), .branch_PC(branch_PC),
        .jump_addr(jump_addr), .stall(st[1]), .flush(fl[1]),
        .target_pc(tg[1]), .WB_Reg(wbr[1]), .RD_Reg(rdr[1]),
        .ALU_Reg(alur[1]), .rd_rt_Reg(rdtr[1]), .misalign_Reg(misr[1])
    );

    mem_stage #(.DEPTH_LOG2(8), .MEM_LAT(4)) u_lat4 (
        .clk(clk), .rst(rst), .WB(WB), .M(M), .ZeroMEM(ZeroMEM),
        .ALUOut(ALUOut), .WD(WD), .rd_rt(rd_rt), .branch_PC(branch_PC),
        .jump_addr(jump_addr), .stall(st[2]), .flush(fl[2]),
        .target_pc(tg[2]), .WB_Reg(wbr[2]), .RD_Reg(rdr[2]),
        .ALU_Reg(alur[2]), .rd_rt_Reg(rdtr[2]), .misalign_Reg(misr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  m;
        logic        z;
        logic [2:0]  wb;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic [31:0] bpc;
        logic [31:0] jpc;
        logic        e_flush;
        logic [31:0] e_tgt;
        logic [2:0]  e_wb;
        logic [31:0] e_rd;
        logic        e_mis;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] m, input logic z, input logic [2:0] wb,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                         input logic [31:0] bpc, input logic [31:0] jpc);
        M = m; ZeroMEM = z; WB = wb; ALUOut = addr; WD = wd; rd_rt = rd;
        branch_PC = bpc; jump_addr = jpc;
    endtask

    // Multi-cycle memory op on instance d with latency lat. Called at
    // posedge+1; returns at posedge+1 after the completion edge.
    task automatic mc_op(input int d, input int lat, input string tag,
                         input logic [3:0] m, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [2:0] wb, input logic [4:0] rd, input logic [31:0] exp_rd);
        drive(m, 1'b0, wb, addr, wd, rd, 32'h0, 32'h0);
        for (int c = 1; c <= lat; c++) begin
            #1;
            check($sformatf("%s_stall_c%0d", tag, c), 32'(st[d]), (c < lat) ? 32'd1 : 32'd0);
            check($sformatf("%s_flush_c%0d", tag, c), 32'(fl[d]), 32'd0);
            @(posedge clk); #1;
            if (c < lat) begin
                check($sformatf("%s_wb_bubble_e%0d", tag, c), 32'(wbr[d]), 32'd0);
                check($sformatf("%s_rd_bubble_e%0d", tag, c), rdr[d], 32'd0);
            end else begin
                check($sformatf("%s_wb_done", tag), 32'(wbr[d]), 32'(wb));
                check($sformatf("%s_rd_done", tag), rdr[d], exp_rd);
                check($sformatf("%s_alu_done", tag), alur[d], addr);
                check($sformatf("%s_rdt_done", tag), 32'(rdtr[d]), 32'(rd));
            end
        end
    endtask

    task automatic check_zero_regs(input int d, input string tag);
        check({tag, "_wb"},  32'(wbr[d]),  32'd0);
        check({tag, "_rd"},  rdr[d],       32'd0);
        check({tag, "_alu"}, alur[d],      32'd0);
        check({tag, "_rdt"}, 32'(rdtr[d]), 32'd0);
        check({tag, "_mis"}, 32'(misr[d]), 32'd0);
    endtask

    function automatic vec_t mk(input string name, input logic [3:0] m, input logic z,
                                input logic [2:0] wb, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [4:0] rd,
                                input logic [31:0] bpc, input logic [31:0] jpc,
                                input logic e_flush, input logic [31:0] e_tgt,
                                input logic [2:0] e_wb, input logic [31:0] e_rd,
                                input logic e_mis);
        vec_t v;
        v.name = name; v.m = m; v.z = z; v.wb = wb; v.addr = addr; v.wd = wd;
        v.rd = rd; v.bpc = bpc; v.jpc = jpc; v.e_flush = e_flush; v.e_tgt = e_tgt;
        v.e_wb = e_wb; v.e_rd = e_rd; v.e_mis = e_mis;
        return v;
    endfunction

    initial begin
        //              name        m        z  wb    addr      wd            rd  bpc    jpc    fl tgt    ewb   erd           mis
        vecs[0]  = mk("st_10",     4'b0001, 0, 3'd5, 32'h010, 32'hDEADBEEF, 5,  32'h0,  32'h0,  0, 32'h0,  3'd5, 32'h0,        0);
        vecs[1]  = mk("ld_10",     4'b0010, 0, 3'd3, 32'h010, 32'h0,        7,  32'h0,  32'h0,  0, 32'h0,  3'd3, 32'hDEADBEEF, 0);
        vecs[2]  = mk("st_mis",    4'b0001, 0, 3'd7, 32'h013, 32'h11111111, 8,  32'h0,  32'h0,  0, 32'h0,  3'd0, 32'h0,        1);
        vecs[3]  = mk("ld_aft_mis",4'b0010, 0, 3'd3, 32'h010, 32'h0,        7,  32'h0,  32'h0,  0, 32'h0,  3'd3, 32'hDEADBEEF, 0);
        vecs[4]  = mk("branch",    4'b0100, 1, 3'd0, 32'h000, 32'h0,        0,  32'h40, 32'h80, 1, 32'h40, 3'd0, 32'h0,        0);
        vecs[5]  = mk("jump_win",  4'b1100, 0, 3'd0, 32'h000, 32'h0,        0,  32'h40, 32'h80, 1, 32'h80, 3'd0, 32'h0,        0);
        vecs[6]  = mk("br_ntaken", 4'b0100, 0, 3'd1, 32'h004, 32'h0,        2,  32'h40, 32'h80, 0, 32'h0,  3'd1, 32'h0,        0);
        vecs[7]  = mk("st_400",    4'b0001, 0, 3'd5, 32'h400, 32'h12345678, 9,  32'h0,  32'h0,  0, 32'h0,  3'd5, 32'h0,        0);
        vecs[8]  = mk("ld_000",    4'b0010, 0, 3'd3, 32'h000, 32'h0,        10, 32'h0,  32'h0,  0, 32'h0,  3'd3, 32'h12345678, 0);
        vecs[9]  = mk("rdwr_20",   4'b0011, 0, 3'd5, 32'h020, 32'hCAFEF00D, 11, 32'h0,  32'h0,  0, 32'h0,  3'd5, 32'h0,        0);
        vecs[10] = mk("ld_20",     4'b0010, 0, 3'd3, 32'h020, 32'h0,        12, 32'h0,  32'h0,  0, 32'h0,  3'd3, 32'hCAFEF00D, 0);
        vecs[11] = mk("ld_mis",    4'b0010, 0, 3'd3, 32'h022, 32'h0,        13, 32'h0,  32'h0,  0, 32'h0,  3'd0, 32'h0,        1);

        // Reset
        rst = 1'b1;
        drive(4'b0000, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check_zero_regs(d, $sformatf("reset_d%0d", d));
            check($sformatf("reset_stall_d%0d", d), 32'(st[d]), 32'd0);
            check($sformatf("reset_flush_d%0d", d), 32'(fl[d]), 32'd0);
        end

        // MEM_LAT=1 vector table
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].m, vecs[i].z, vecs[i].wb, vecs[i].addr, vecs[i].wd,
                  vecs[i].rd, vecs[i].bpc, vecs[i].jpc);
            #1;
            check({vecs[i].name, "_stall"}, 32'(st[0]), 32'd0);
            check({vecs[i].name, "_flush"}, 32'(fl[0]), 32'(vecs[i].e_flush));
            if (vecs[i].e_flush)
                check({vecs[i].name, "_target"}, tg[0], vecs[i].e_tgt);
            @(posedge clk); #1;
            check({vecs[i].name, "_wb"},  32'(wbr[0]),  32'(vecs[i].e_wb));
            check({vecs[i].name, "_rd"},  rdr[0],       vecs[i].e_rd);
            check({vecs[i].name, "_alu"}, alur[0],      vecs[i].addr);
            check({vecs[i].name, "_rdt"}, 32'(rdtr[0]), 32'(vecs[i].rd));
            check({vecs[i].name, "_mis"}, 32'(misr[0]), 32'(vecs[i].e_mis));
        end

        // MEM_LAT=3: store then back-to-back load
        rst = 1'b1;
        drive(4'b0000, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        mc_op(1, 3, "l3_st", 4'b0001, 32'h20, 32'hA5A5A5A5, 3'd5, 5'd3, 32'h0);
        mc_op(1, 3, "l3_ld", 4'b0010, 32'h20, 32'h0,        3'd3, 5'd4, 32'hA5A5A5A5);

        // Redirect is suppressed while stalled
        drive(4'b1110, 1'b1, 3'd0, 32'h20, 32'h0, 5'd0, 32'h40, 32'h80);
        #1;
        check("l3_flush_masked", 32'(fl[1]), 32'd0);
        check("l1_flush_unmasked", 32'(fl[0]), 32'd1);

        // MEM_LAT=4: reset during a pending store drops the store
        rst = 1'b1;
        drive(4'b0000, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        mc_op(2, 4, "l4_st1", 4'b0001, 32'h30, 32'h11112222, 3'd5, 5'd6, 32'h0);
        drive(4'b0001, 1'b0, 3'd5, 32'h30, 32'h99999999, 5'd6, 32'h0, 32'h0);
        #1;
        check("l4_st2_stall_c1", 32'(st[2]), 32'd1);
        @(posedge clk); #1;
        #1;
        check("l4_st2_stall_c2", 32'(st[2]), 32'd1);
        @(posedge clk); #1;
        // cnt is now 2
        rst = 1'b1;
        drive(4'b0000, 1'b0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero_regs(2, "l4_rst_busy");
        check("l4_rst_stall", 32'(st[2]), 32'd0);
        mc_op(2, 4, "l4_ld", 4'b0010, 32'h30, 32'h0, 3'd3, 5'd7, 32'h11112222);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
